// File: rtl/reg_bank32.sv
// reg_bank32: 32 x WIDTH register file with two combinational read ports, one
// write port, optional write-to-read forwarding and a committed-write counter.
module reg_bank32 #(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [4:0]       wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [4:0]       ra1,
   input  logic [4:0]       ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic [7:0]       wr_cnt
);

   // r0 has no storage; it is a hardwired zero in every read slice.
   logic [WIDTH-1:0] mem [1:31];
   logic             commit;
   logic             fwd1;
   logic             fwd2;
   logic [WIDTH-1:0] rd1_raw;
   logic [WIDTH-1:0] rd2_raw;

   assign commit = we && !reset && (wa != 5'd0);

   // NOTE: the storage is cleared by reset on purpose, so every read is X-free after the first reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 1; n < 32; n++) begin
            mem[n] <= '0;
         end
         wr_cnt <= '0;
      end else if (commit) begin
         mem[wa] <= wd;
         wr_cnt  <= wr_cnt + 8'd1;
      end
   end

   // One 32:1 selector per data bit and per port.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [31:0] col;
      assign col[0] = 1'b0;
      for (genvar n = 1; n < 32; n++) begin : g_reg
         assign col[n] = mem[n][i];
      end
      assign rd1_raw[i] = col[ra1];
      assign rd2_raw[i] = col[ra2];
   end

   // Forwarding follows commit, so reset and writes to r0 never forward.
   assign fwd1 = BYPASS && commit && (ra1 == wa);
   assign fwd2 = BYPASS && commit && (ra2 == wa);
   assign rd1  = fwd1 ? wd : rd1_raw;
   assign rd2  = fwd2 ? wd : rd2_raw;

endmodule

// File: tb/tb_reg_bank32.sv
// Directed bench for reg_bank32: one forwarding and one non-forwarding instance
// driven by identical stimulus, checked before each rising edge.
module tb_reg_bank32;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         we;
   logic [4:0]   wa;
   logic [W-1:0] wd;
   logic [4:0]   ra1;
   logic [4:0]   ra2;
   logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic [7:0]   cnt_b, cnt_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_bank32 #(.WIDTH(W), .BYPASS(1'b1)) dut_b (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .wr_cnt(cnt_b)
   );

   reg_bank32 #(.WIDTH(W), .BYPASS(1'b0)) dut_n (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n), .wr_cnt(cnt_n)
   );

   typedef struct {
      logic         we;
      logic [4:0]   wa;
      logic [W-1:0] wd;
      logic [4:0]   ra1;
      logic [4:0]   ra2;
      logic [W-1:0] b1;   // forwarding instance rd1/rd2
      logic [W-1:0] b2;
      logic [W-1:0] n1;   // non-forwarding instance rd1/rd2
      logic [W-1:0] n2;
      logic [7:0]   cnt;  // wr_cnt before the edge
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [W-1:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
      we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0,        8'd0};
      vecs[1] = '{1'b1, 5'd3, 32'hDEADBEEF, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        8'd0};
      vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 8'd1};
      vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 8'd1};
      vecs[4] = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        8'd1};
      vecs[5] = '{1'b1, 5'd7, 32'h12345678, 5'd3,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0,        8'd1};
      vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 8'd2};
      vecs[7] = '{1'b1, 5'd7, 32'hAAAA5555, 5'd7,  5'd3,  32'hAAAA5555, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 8'd2};
      vecs[8] = '{1'b1, 5'd7, 32'h0000FFFF, 5'd7,  5'd7,  32'h0000FFFF, 32'h0000FFFF, 32'hAAAA5555, 32'hAAAA5555, 8'd3};
      vecs[9] = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd3,  32'h0000FFFF, 32'hDEADBEEF, 32'h0000FFFF, 32'hDEADBEEF, 8'd4};

      do_reset();

      // Table: inputs applied after the falling edge, outputs checked before the rising edge.
      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
         #2;
         check($sformatf("vec%0d rd1_byp", v), rd1_b, vecs[v].b1);
         check($sformatf("vec%0d rd2_byp", v), rd2_b, vecs[v].b2);
         check($sformatf("vec%0d rd1_nobyp", v), rd1_n, vecs[v].n1);
         check($sformatf("vec%0d rd2_nobyp", v), rd2_n, vecs[v].n2);
         check($sformatf("vec%0d wr_cnt", v), {24'h0, cnt_b}, {24'h0, vecs[v].cnt});
         @(negedge clk);
      end

      // Fill all nonzero registers, then read every (n, 31-n) pair.
      do_reset();
      for (int n = 1; n < 32; n++) begin
         drive(1'b1, 5'(n), 32'h100 + n, 5'd0, 5'd0);
         @(negedge clk);
      end
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
      for (int n = 0; n < 32; n++) begin
         logic [W-1:0] e1, e2;
         e1 = (n == 0) ? 32'h0 : 32'h100 + n;
         e2 = (n == 31) ? 32'h0 : 32'h100 + (31 - n);
         ra1 = 5'(n);
         ra2 = 5'(31 - n);
         #1;
         check($sformatf("fill rd1_byp r%0d", n), rd1_b, e1);
         check($sformatf("fill rd2_byp r%0d", 31 - n), rd2_b, e2);
         check($sformatf("fill rd1_nobyp r%0d", n), rd1_n, e1);
         check($sformatf("fill rd2_nobyp r%0d", 31 - n), rd2_n, e2);
      end
      check("fill wr_cnt", {24'h0, cnt_b}, 32'd31);
      check("fill wr_cnt_nobyp", {24'h0, cnt_n}, 32'd31);

      // 256 writes to r1 wrap the counter back to its start value.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 5'd1, 32'(i), 5'd1, 5'd1);
         if (i == 255) begin
            #2;
            check("wrap cnt at 255", {24'h0, cnt_b}, 32'd255);
         end
         @(negedge clk);
      end
      drive(1'b0, 5'd0, '0, 5'd1, 5'd0);
      #2;
      check("wrap cnt to 0", {24'h0, cnt_b}, 32'd0);
      check("wrap r1 last value", rd1_b, 32'd255);

      // A write alongside reset is blocked and not forwarded.
      reset = 1'b1;
      drive(1'b1, 5'd1, 32'h0000CAFE, 5'd1, 5'd1);
      #2;
      check("reset no fwd rd1", rd1_b, 32'd255);
      check("reset no fwd rd2", rd2_b, 32'd255);
      @(negedge clk);
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
      for (int n = 0; n < 32; n++) begin
         ra1 = 5'(n);
         ra2 = 5'(31 - n);
         #1;
         check($sformatf("post reset rd1 r%0d", n), rd1_b, 32'h0);
         check($sformatf("post reset rd2 r%0d", 31 - n), rd2_n, 32'h0);
      end
      check("post reset cnt", {24'h0, cnt_b}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // First write after reset commits normally.
      drive(1'b1, 5'd2, 32'h00000055, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b0, 5'd0, '0, 5'd1, 5'd2);
      #2;
      check("after reset r1", rd1_n, 32'h0);
      check("after reset r2", rd2_n, 32'h55);
      check("after reset cnt", {24'h0, cnt_n}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
